// File: rtl/pong_game_core.sv
`default_nettype none
// ============================================================================
// Module  : pong_game_core
// Brief   : Pong engine - paddles, ball physics, rally speed-up, scoring and
//           match FSM; all motion advances on the single-cycle frame_tick.
// Revision: 1.0 - initial release
// ============================================================================
module pong_game_core #(
  parameter int COORD_W     = 10,
  parameter int H_RES       = 640,
  parameter int V_RES       = 480,
  parameter int BALL_SIZE   = 6,
  parameter int PADDLE_W    = 4,
  parameter int PADDLE_H    = 40,
  parameter int PADDLE_STEP = 2,
  parameter int VEL_INIT    = 1,
  parameter int VEL_MAX     = 4,
  parameter int HITS_PER_UP = 4,
  parameter int WIN_SCORE   = 11,
  parameter int SCORE_W     = 4,
  parameter int SERVE_DELAY = 60
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               serve,
  input  logic               p1_up,
  input  logic               p1_down,
  input  logic               p2_up,
  input  logic               p2_down,
  output logic [COORD_W-1:0] paddle1_y,
  output logic [COORD_W-1:0] paddle2_y,
  output logic [COORD_W-1:0] ball_x,
  output logic [COORD_W-1:0] ball_y,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score,
  output logic               point_p1,
  output logic               point_p2,
  output logic [2:0]         game_state,
  output logic               winner
);
  // Extended width so edge arithmetic can never overflow the coordinate range
  localparam int EW    = COORD_W + 2;
  localparam int DLY_W = $clog2(SERVE_DELAY + 2);
  localparam int HIT_W = $clog2(HITS_PER_UP + 1);

  localparam logic [EW-1:0] c_step   = EW'(PADDLE_STEP);
  localparam logic [EW-1:0] c_pmax   = EW'(V_RES - PADDLE_H);
  localparam logic [EW-1:0] c_bs     = EW'(BALL_SIZE);
  localparam logic [EW-1:0] c_vres   = EW'(V_RES);
  localparam logic [EW-1:0] c_pw     = EW'(PADDLE_W);
  localparam logic [EW-1:0] c_ph     = EW'(PADDLE_H);
  localparam logic [EW-1:0] c_p2edge = EW'(H_RES - PADDLE_W);
  localparam logic [EW-1:0] c_vmax   = EW'(VEL_MAX);

  localparam logic [COORD_W-1:0] c_cx    = COORD_W'((H_RES - BALL_SIZE) / 2);
  localparam logic [COORD_W-1:0] c_cy    = COORD_W'((V_RES - BALL_SIZE) / 2);
  localparam logic [COORD_W-1:0] c_pmid  = COORD_W'((V_RES - PADDLE_H) / 2);
  localparam logic [COORD_W-1:0] c_ymax  = COORD_W'(V_RES - BALL_SIZE);
  localparam logic [COORD_W-1:0] c_x1hit = COORD_W'(PADDLE_W);
  localparam logic [COORD_W-1:0] c_x2hit = COORD_W'(H_RES - PADDLE_W - BALL_SIZE);
  localparam logic [COORD_W-1:0] c_vinit = COORD_W'(VEL_INIT);
  localparam logic [SCORE_W-1:0] c_win   = SCORE_W'(WIN_SCORE);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_POINT = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  state_t             r_state;
  logic [COORD_W-1:0] r_p1_y, r_p2_y, r_ball_x, r_ball_y, r_vx, r_vy;
  logic               r_dir_x, r_dir_y;  // 1 = right / down
  logic [SCORE_W-1:0] r_p1_score, r_p2_score;
  logic               r_point_p1, r_point_p2, r_winner;
  logic [DLY_W-1:0]   r_dly;
  logic [HIT_W-1:0]   r_hits;

  logic [EW-1:0]      w_bx, w_by, w_vx, w_vy, w_p1, w_p2;
  logic [COORD_W-1:0] w_nx, w_ny, w_vx_up;
  logic               w_ndx, w_ndy, w_hit, w_miss;
  logic [HIT_W-1:0]   w_hits_inc;

  function automatic logic [COORD_W-1:0] f_paddle(input logic [COORD_W-1:0] y,
                                                  input logic up, input logic dn);
    logic [EW-1:0] ye;
    ye = EW'(y);
    if (up && !dn)
      ye = (ye <= c_step) ? '0 : ye - c_step;
    else if (dn && !up)
      ye = (ye + c_step >= c_pmax) ? c_pmax : ye + c_step;
    return COORD_W'(ye);
  endfunction

  assign w_bx       = EW'(r_ball_x);
  assign w_by       = EW'(r_ball_y);
  assign w_vx       = EW'(r_vx);
  assign w_vy       = EW'(r_vy);
  assign w_p1       = EW'(r_p1_y);
  assign w_p2       = EW'(r_p2_y);
  assign w_hits_inc = r_hits + HIT_W'(1);
  assign w_vx_up    = (w_vx >= c_vmax) ? COORD_W'(c_vmax) : COORD_W'(w_vx + EW'(1));

  // Next ball position; both axes judged from the current registers
  always_comb begin
    w_ny   = r_ball_y;
    w_ndy  = r_dir_y;
    w_nx   = r_ball_x;
    w_ndx  = r_dir_x;
    w_hit  = 1'b0;
    w_miss = 1'b0;
    if (!r_dir_y) begin
      if (w_by <= w_vy) begin
        w_ny  = '0;
        w_ndy = 1'b1;
      end else begin
        w_ny = COORD_W'(w_by - w_vy);
      end
    end else if (w_by + c_bs + w_vy >= c_vres) begin
      w_ny  = c_ymax;
      w_ndy = 1'b0;
    end else begin
      w_ny = COORD_W'(w_by + w_vy);
    end

    if (!r_dir_x) begin
      if (w_bx <= c_pw + w_vx) begin
        if ((w_by + c_bs > w_p1) && (w_by < w_p1 + c_ph)) begin
          w_nx  = c_x1hit;
          w_ndx = 1'b1;
          w_hit = 1'b1;
        end else begin
          w_miss = 1'b1;
        end
      end else begin
        w_nx = COORD_W'(w_bx - w_vx);
      end
    end else begin
      if (w_bx + c_bs + w_vx >= c_p2edge) begin
        if ((w_by + c_bs > w_p2) && (w_by < w_p2 + c_ph)) begin
          w_nx  = c_x2hit;
          w_ndx = 1'b0;
          w_hit = 1'b1;
        end else begin
          w_miss = 1'b1;
        end
      end else begin
        w_nx = COORD_W'(w_bx + w_vx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_p1_y     <= c_pmid;
      r_p2_y     <= c_pmid;
      r_ball_x   <= c_cx;
      r_ball_y   <= c_cy;
      r_dir_x    <= 1'b1;
      r_dir_y    <= 1'b1;
      r_vx       <= c_vinit;
      r_vy       <= c_vinit;
      r_hits     <= '0;
      r_dly      <= DLY_W'(SERVE_DELAY);
      r_p1_score <= '0;
      r_p2_score <= '0;
      r_point_p1 <= 1'b0;
      r_point_p2 <= 1'b0;
      r_winner   <= 1'b0;
    end else begin
      r_point_p1 <= 1'b0;
      r_point_p2 <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (serve) begin
            r_state <= S_SERVE;
            r_dly   <= DLY_W'(SERVE_DELAY);
          end
        end
        S_SERVE: begin
          // Serve conditions are re-asserted every cycle while waiting
          r_ball_x <= c_cx;
          r_ball_y <= c_cy;
          r_vx     <= c_vinit;
          r_vy     <= c_vinit;
          r_hits   <= '0;
          if (frame_tick) begin
            r_p1_y <= f_paddle(r_p1_y, p1_up, p1_down);
            r_p2_y <= f_paddle(r_p2_y, p2_up, p2_down);
            if (r_dly == '0) r_state <= S_PLAY;
            else             r_dly   <= r_dly - DLY_W'(1);
          end
        end
        S_PLAY: begin
          if (frame_tick) begin
            r_p1_y   <= f_paddle(r_p1_y, p1_up, p1_down);
            r_p2_y   <= f_paddle(r_p2_y, p2_up, p2_down);
            r_ball_y <= w_ny;
            r_dir_y  <= w_ndy;
            if (w_miss) begin
              // dir_x already points at the player who missed
              r_state  <= S_POINT;
              r_ball_x <= c_cx;
              r_ball_y <= c_cy;
              if (r_dir_x) begin
                r_p1_score <= r_p1_score + SCORE_W'(1);
                r_point_p1 <= 1'b1;
              end else begin
                r_p2_score <= r_p2_score + SCORE_W'(1);
                r_point_p2 <= 1'b1;
              end
            end else begin
              r_ball_x <= w_nx;
              r_dir_x  <= w_ndx;
              if (w_hit) begin
                if (w_hits_inc == HIT_W'(HITS_PER_UP)) begin
                  r_hits <= '0;
                  r_vx   <= w_vx_up;
                end else begin
                  r_hits <= w_hits_inc;
                end
              end
            end
          end
        end
        S_POINT: begin
          if (r_p1_score == c_win) begin
            r_state  <= S_OVER;
            r_winner <= 1'b0;
          end else if (r_p2_score == c_win) begin
            r_state  <= S_OVER;
            r_winner <= 1'b1;
          end else begin
            r_state <= S_SERVE;
            r_dly   <= DLY_W'(SERVE_DELAY);
          end
        end
        S_OVER: begin
          if (serve) begin
            r_p1_score <= '0;
            r_p2_score <= '0;
            r_winner   <= 1'b0;
            r_state    <= S_SERVE;
            r_dly      <= DLY_W'(SERVE_DELAY);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign paddle1_y  = r_p1_y;
  assign paddle2_y  = r_p2_y;
  assign ball_x     = r_ball_x;
  assign ball_y     = r_ball_y;
  assign p1_score   = r_p1_score;
  assign p2_score   = r_p2_score;
  assign point_p1   = r_point_p1;
  assign point_p2   = r_point_p2;
  assign game_state = r_state;
  assign winner     = r_winner;

endmodule
`default_nettype wire
